// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch constants, entry type and PC alignment helper
package fetch_pkg;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with a registered head
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        rd_next = rd_ptr;
        if (flush) begin
            rd_next = '0;
        end else if (do_pop) begin
            rd_next = rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Head register tracks the entry that will sit at rd_next, bypassing a same-cycle write into that slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_data <= '0;
        end else if (flush) begin
            head_data <= '0;
        end else if (do_push && (wr_ptr == rd_next)) begin
            head_data <= push_data;
        end else begin
            head_data <= mem[rd_next];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with credit-limited requests and redirect flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] pending;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_discard;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Every outstanding request owns a FIFO slot, so a response can never find the buffer full.
    assign credit_used   = (CW + 1)'(pending) + (CW + 1)'(fifo_count);
    assign mem_req_valid = reset_n && !redirect && (credit_used < DEPTH_C);
    assign mem_req_addr  = fetch_pc;

    assign req_fire    = mem_req_valid && mem_req_ready;
    assign rsp_discard = mem_rsp_valid && ((drop != '0) || redirect);
    assign fifo_push   = mem_rsp_valid && !rsp_discard;
    assign fifo_pop    = instr_valid && instr_ready && !redirect;
    assign push_entry  = '{pc: rsp_pc, instr: mem_rsp_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            pending  <= '0;
            drop     <= '0;
        end else begin
            pending <= pending + CW'(req_fire) - CW'(mem_rsp_valid);
            if (redirect) begin
                fetch_pc <= align_pc(redirect_pc);
                rsp_pc   <= align_pc(redirect_pc);
                drop     <= pending - CW'(mem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (fifo_push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (mem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

    overflow_check: assert property (@(posedge clk) disable iff (!reset_n) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a fixed-latency in-order memory model
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int          cyc;
    int          lat;
    int          issued;
    int          n_cmp;
    int          n_err;
    logic [31:0] q_addr[$];
    int          q_due[$];

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory returns ~addr as the instruction word, lat cycles after the accepting cycle.
    task automatic tick();
        @(negedge clk);
        if (reset_n && mem_req_valid && mem_req_ready) begin
            q_addr.push_back(mem_req_addr);
            q_due.push_back(cyc + lat);
            issued++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = ~q_addr[0];
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset(input int latency, input bit chk);
        reset_n       = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_req_ready = 1'b1;
        q_addr.delete();
        q_due.delete();
        lat    = latency;
        issued = 0;
        repeat (2) @(posedge clk);
        #1;
        if (chk) begin
            check_eq("rst req_valid", 32'(mem_req_valid), 32'd0);
            check_eq("rst instr_valid", 32'(instr_valid), 32'd0);
            check_eq("rst instr", instr, 32'h0);
            check_eq("rst instr_pc", instr_pc, 32'h0);
        end
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        instr_ready = 1'b1;

        // Zero-wait memory, free-running consumer
        do_reset(1, 1'b1);
        instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            #1;
            if (c == 0) begin
                check_eq("t1 first req_valid", 32'(mem_req_valid), 32'd1);
                check_eq("t1 first req_addr", mem_req_addr, 32'h0);
            end else if (c == 1) begin
                check_eq("t1 c1 instr_valid", 32'(instr_valid), 32'd0);
            end else begin
                check_eq($sformatf("t1 c%0d instr_valid", c), 32'(instr_valid), 32'd1);
                check_eq($sformatf("t1 c%0d instr_pc", c), instr_pc, 32'((c - 2) * 4));
                check_eq($sformatf("t1 c%0d instr", c), instr, ~32'((c - 2) * 4));
            end
        end

        // 3-cycle memory, stalled consumer: credit limit of four requests
        do_reset(3, 1'b0);
        instr_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            #1;
            if (c < 4) begin
                check_eq($sformatf("t2 c%0d req_valid", c), 32'(mem_req_valid), 32'd1);
                check_eq($sformatf("t2 c%0d req_addr", c), mem_req_addr, 32'(c * 4));
            end else begin
                check_eq($sformatf("t2 c%0d req_valid", c), 32'(mem_req_valid), 32'd0);
            end
        end
        check_eq("t2 issued", 32'(issued), 32'd4);
        check_eq("t2 head valid", 32'(instr_valid), 32'd1);
        check_eq("t2 head pc", instr_pc, 32'h0);

        // Redirect to unaligned 0x103 with three requests in flight
        do_reset(4, 1'b0);
        instr_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            if (c == 3) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0103;
            end else begin
                redirect = 1'b0;
            end
            #1;
            if (c == 3) check_eq("t3 redirect req_valid", 32'(mem_req_valid), 32'd0);
            if (c == 4) begin
                check_eq("t3 target req_valid", 32'(mem_req_valid), 32'd1);
                check_eq("t3 target req_addr", mem_req_addr, 32'h0000_0100);
            end
            if (c >= 4 && c <= 8) check_eq($sformatf("t3 c%0d instr_valid", c), 32'(instr_valid), 32'd0);
            if (c == 9) begin
                check_eq("t3 c9 instr_valid", 32'(instr_valid), 32'd1);
                check_eq("t3 c9 instr_pc", instr_pc, 32'h0000_0100);
                check_eq("t3 c9 instr", instr, ~32'h0000_0100);
            end
            if (c == 10) check_eq("t3 c10 instr_pc", instr_pc, 32'h0000_0104);
        end

        // Redirect coinciding with a response and a would-be pop
        do_reset(2, 1'b0);
        instr_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) tick();
            if (c == 3) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0200;
            end else begin
                redirect = 1'b0;
            end
            #1;
            if (c == 3) begin
                check_eq("t4 c3 rsp_valid", 32'(mem_rsp_valid), 32'd1);
                check_eq("t4 c3 head pc", instr_pc, 32'h0);
            end
            if (c == 4) check_eq("t4 c4 req_addr", mem_req_addr, 32'h0000_0200);
            if (c >= 4 && c <= 6) check_eq($sformatf("t4 c%0d instr_valid", c), 32'(instr_valid), 32'd0);
            if (c == 7) begin
                check_eq("t4 c7 instr_valid", 32'(instr_valid), 32'd1);
                check_eq("t4 c7 instr_pc", instr_pc, 32'h0000_0200);
            end
        end

        // PC wrap through 0xFFFF_FFFC
        do_reset(1, 1'b0);
        instr_ready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) tick();
            if (c == 0) begin
                redirect    = 1'b1;
                redirect_pc = 32'hFFFF_FFF8;
            end else begin
                redirect = 1'b0;
            end
            #1;
            if (c == 0) check_eq("t5 redirect req_valid", 32'(mem_req_valid), 32'd0);
            if (c == 1) check_eq("t5 c1 req_addr", mem_req_addr, 32'hFFFF_FFF8);
            if (c == 2) check_eq("t5 c2 req_addr", mem_req_addr, 32'hFFFF_FFFC);
            if (c == 3) check_eq("t5 c3 req_addr", mem_req_addr, 32'h0000_0000);
            if (c == 3) check_eq("t5 c3 instr_pc", instr_pc, 32'hFFFF_FFF8);
            if (c == 4) check_eq("t5 c4 instr_pc", instr_pc, 32'hFFFF_FFFC);
            if (c == 5) check_eq("t5 c5 instr_pc", instr_pc, 32'h0000_0000);
            if (c == 6) check_eq("t5 c6 instr_pc", instr_pc, 32'h0000_0004);
        end

        // Asynchronous reset with the FIFO half full
        do_reset(1, 1'b0);
        instr_ready = 1'b0;
        repeat (3) tick();
        #1;
        check_eq("t6 pre valid", 32'(instr_valid), 32'd1);
        check_eq("t6 pre pc", instr_pc, 32'h0);
        reset_n = 1'b0;
        #1;
        check_eq("t6 async instr_valid", 32'(instr_valid), 32'd0);
        check_eq("t6 async instr", instr, 32'h0);
        check_eq("t6 async instr_pc", instr_pc, 32'h0);
        check_eq("t6 async req_valid", 32'(mem_req_valid), 32'd0);
        do_reset(1, 1'b0);
        instr_ready = 1'b1;
        #1;
        check_eq("t6 restart req_addr", mem_req_addr, 32'h0);
        check_eq("t6 restart req_valid", 32'(mem_req_valid), 32'd1);
        tick();
        tick();
        #1;
        check_eq("t6 restart instr_valid", 32'(instr_valid), 32'd1);
        check_eq("t6 restart instr_pc", instr_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
